// File: rtl/bus_region_mux.sv
// 65C02 bus fabric: address decode, registered read mux, per-region wait
// states via RDY, read-only write blocking and halt-address detection.
module bus_region_mux #(
    parameter int                NUM_REGIONS  = 4,
    parameter logic [8*16-1:0]   REGION_BASE  = {8{16'h0000}},
    parameter logic [8*17-1:0]   REGION_SIZE  = {8{17'h0}},
    parameter logic [8*4-1:0]    REGION_WAIT  = {8{4'h0}},
    parameter logic [7:0]        REGION_RO    = 8'h00,
    parameter logic [7:0]        UNMAPPED_VAL = 8'hEA,
    parameter logic [15:0]       HALT_ADDR    = 16'hFFFF,
    parameter int                HALT_CYCLES  = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [15:0]              cpu_addr_i,
    input  logic                     cpu_we_i,
    input  logic [7:0]               cpu_dout_i,
    output logic [7:0]               cpu_din_o,
    output logic                     cpu_rdy_o,
    output logic [NUM_REGIONS-1:0]   region_cs_o,
    output logic [15:0]              region_off_o,
    output logic [NUM_REGIONS-1:0]   region_we_o,
    output logic [7:0]               region_wdata_o,
    input  logic [8*NUM_REGIONS-1:0] region_rdata_i,
    output logic                     ro_err_o,
    output logic                     halted_o
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [15:0]            addr_q;
    logic [7:0]             din_q, din_d;
    logic [7:0]             hcnt_q, hcnt_d;
    logic                   halted_q, halted_d;

    logic                   hit;
    logic [NUM_REGIONS-1:0] sel_oh;
    logic [15:0]            sel_base;
    logic [3:0]             sel_wait;
    logic                   sel_ro;
    logic [7:0]             sel_rdata;
    logic                   stall;
    logic                   complete;
    logic                   addr_chg;
    logic                   halt_hit;

    // Lowest index wins; bounds compared at 17 bits so a region may end at 0xFFFF
    always_comb begin : decode
        logic [16:0] lo;
        logic [16:0] hi;
        hit       = 1'b0;
        sel_oh    = '0;
        sel_base  = 16'h0000;
        sel_wait  = 4'h0;
        sel_ro    = 1'b0;
        sel_rdata = UNMAPPED_VAL;
        lo        = 17'h0;
        hi        = 17'h0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            lo = {1'b0, REGION_BASE[r*16 +: 16]};
            hi = lo + REGION_SIZE[r*17 +: 17];
            if (!hit && {1'b0, cpu_addr_i} >= lo && {1'b0, cpu_addr_i} < hi) begin
                hit       = 1'b1;
                sel_oh[r] = 1'b1;
                sel_base  = REGION_BASE[r*16 +: 16];
                sel_wait  = REGION_WAIT[r*4 +: 4];
                sel_ro    = REGION_RO[r];
                sel_rdata = region_rdata_i[r*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'h0;
            done_q   <= 1'b0;
            addr_q   <= 16'h0000;
            din_q    <= UNMAPPED_VAL;
            hcnt_q   <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            addr_q   <= cpu_addr_i;
            din_q    <= din_d;
            hcnt_q   <= hcnt_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        addr_chg = cpu_addr_i != addr_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        stall    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_wait == 4'h0 || (done_q && !addr_chg)) begin
                    complete = 1'b1;
                    done_d   = 1'b0;
                end else begin
                    stall = 1'b1;
                    // A single wait state needs no STALL visit
                    if (sel_wait == 4'h1) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = STALL;
                        cnt_d   = sel_wait - 4'h1;
                        done_d  = 1'b0;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (addr_chg) begin
                    state_d = IDLE;
                    cnt_d   = 4'h0;
                    done_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'h1;
                    if (cnt_q <= 4'h1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        din_d = (complete && !cpu_we_i) ? sel_rdata : din_q;

        halt_hit = cpu_addr_i == HALT_ADDR;
        if (!halt_hit)
            hcnt_d = 8'h00;
        else if ({24'h0, hcnt_q} >= HALT_CYCLES)
            hcnt_d = hcnt_q;
        else
            hcnt_d = hcnt_q + 8'h01;
        halted_d = halted_q
                 | (halt_hit && ({24'h0, hcnt_q} + 32'd1 >= HALT_CYCLES));
    end

    always_comb begin
        logic wr;
        wr             = !rst_i && complete && cpu_we_i && hit;
        cpu_rdy_o      = rst_i || !stall;
        region_cs_o    = rst_i ? '0 : sel_oh;
        region_we_o    = (wr && !sel_ro) ? sel_oh : '0;
        ro_err_o       = wr && sel_ro;
        region_off_o   = hit ? cpu_addr_i - sel_base : 16'h0000;
        region_wdata_o = cpu_dout_i;
        cpu_din_o      = din_q;
        halted_o       = halted_q;
    end

endmodule

// File: tb/tb_bus_region_mux.sv
// Scoreboard bench for bus_region_mux: decode, wait states, RO blocking,
// unmapped reads, overlap priority, halt detection and reset mid-stall.
module tb_bus_region_mux;

    localparam int NR = 6;

    logic          clk;
    logic          rst;
    logic [15:0]   cpu_addr;
    logic          cpu_we;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          cpu_rdy;
    logic [NR-1:0] region_cs;
    logic [15:0]   region_off;
    logic [NR-1:0] region_we;
    logic [7:0]    region_wdata;
    logic [8*NR-1:0] region_rdata;
    logic          ro_err;
    logic          halted;

    int n_checks = 0;
    int n_errors = 0;
    int we_pulses = 0;
    int err_pulses = 0;
    logic [7:0] exp_q[$];

    assign region_rdata = {8'h55, 8'h44, 8'h33, 8'h5A, 8'h22, 8'h11};

    bus_region_mux #(
        .NUM_REGIONS (NR),
        .REGION_BASE ({16'h0, 16'h0, 16'hC000, 16'hA100,
                       16'hA000, 16'h0000, 16'h8000, 16'h8000}),
        .REGION_SIZE ({17'h0, 17'h0, 17'h01000, 17'h00100,
                       17'h00008, 17'h08000, 17'h02000, 17'h01000}),
        .REGION_WAIT ({4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0}),
        .REGION_RO   (8'b0010_0000),
        .UNMAPPED_VAL(8'hEA),
        .HALT_ADDR   (16'hFFFF),
        .HALT_CYCLES (5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_addr_i    (cpu_addr),
        .cpu_we_i      (cpu_we),
        .cpu_dout_i    (cpu_dout),
        .cpu_din_o     (cpu_din),
        .cpu_rdy_o     (cpu_rdy),
        .region_cs_o   (region_cs),
        .region_off_o  (region_off),
        .region_we_o   (region_we),
        .region_wdata_o(region_wdata),
        .region_rdata_i(region_rdata),
        .ro_err_o      (ro_err),
        .halted_o      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (|region_we) we_pulses++;
        if (ro_err) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(output int lows);
        lows = 0;
        while (cpu_rdy !== 1'b1 && lows < 20) begin
            lows++;
            @(negedge clk); #1;
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp,
                      input int w, input logic [NR-1:0] cs,
                      input logic [15:0] off);
        int lows;
        cpu_addr = a;
        cpu_we   = 1'b0;
        exp_q.push_back(exp);
        #1;
        chk("rd_cs", 32'(region_cs), 32'(cs));
        chk("rd_off", 32'(region_off), 32'(off));
        wait_rdy(lows);
        chk("rd_stall", lows, w);
        @(negedge clk); #1;
        chk("rd_din", 32'(cpu_din), 32'(exp_q.pop_front()));
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d,
                      input int w, input logic [NR-1:0] exp_we,
                      input logic exp_err);
        int lows;
        int we0;
        int er0;
        we0      = we_pulses;
        er0      = err_pulses;
        cpu_addr = a;
        cpu_we   = 1'b1;
        cpu_dout = d;
        #1;
        chk("wr_wdata", 32'(region_wdata), 32'(d));
        wait_rdy(lows);
        chk("wr_stall", lows, w);
        chk("wr_we", 32'(region_we), 32'(exp_we));
        chk("wr_roerr", 32'(ro_err), 32'(exp_err));
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("wr_we_cnt", we_pulses - we0, (exp_we != '0) ? 1 : 0);
        chk("wr_err_cnt", err_pulses - er0, exp_err ? 1 : 0);
    endtask

    initial begin
        rst      = 1'b1;
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        cpu_dout = 8'h00;
        repeat (2) @(negedge clk);
        cpu_addr = 16'h1234;
        #1;
        chk("rst_din", 32'(cpu_din), 32'hEA);
        chk("rst_rdy", 32'(cpu_rdy), 32'h1);
        chk("rst_cs", 32'(region_cs), 32'h0);
        chk("rst_we", 32'(region_we), 32'h0);
        chk("rst_roerr", 32'(ro_err), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rd(16'h1234, 8'h5A, 0, 6'b000100, 16'h1234);
        rd(16'hA002, 8'h33, 3, 6'b001000, 16'h0002);
        wr(16'hA105, 8'h77, 2, 6'b010000, 1'b0);
        wr(16'hC010, 8'h99, 1, 6'b000000, 1'b1);
        rd(16'hB000, 8'hEA, 0, 6'b000000, 16'h0000);
        rd(16'h8800, 8'h11, 0, 6'b000001, 16'h0800);
        rd(16'h9800, 8'h22, 0, 6'b000010, 16'h1800);
        rd(16'h0010, 8'h5A, 0, 6'b000100, 16'h0010);
        wr(16'hB000, 8'h12, 0, 6'b000000, 1'b0);
        rd(16'hA007, 8'h33, 3, 6'b001000, 16'h0007);

        cpu_addr = 16'hFFFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            chk("halt_early", 32'(halted), 32'h0);
        end
        cpu_addr = 16'h0000;
        @(negedge clk); #1;
        chk("halt_break", 32'(halted), 32'h0);
        cpu_addr = 16'hFFFF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            chk("halt_run", 32'(halted), (k == 5) ? 32'h1 : 32'h0);
        end
        cpu_addr = 16'h0000;
        @(negedge clk); #1;
        chk("halt_sticky", 32'(halted), 32'h1);

        cpu_addr = 16'hA000;
        @(negedge clk); #1;
        chk("mid_stall_rdy", 32'(cpu_rdy), 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_force_rdy", 32'(cpu_rdy), 32'h1);
        chk("rst_force_cs", 32'(region_cs), 32'h0);
        @(negedge clk); #1;
        chk("rst2_din", 32'(cpu_din), 32'hEA);
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_we", 32'(region_we), 32'h0);
        chk("rst2_roerr", 32'(ro_err), 32'h0);
        chk("rst2_rdy", 32'(cpu_rdy), 32'h1);
        rst = 1'b0;
        rd(16'hA002, 8'h33, 3, 6'b001000, 16'h0002);
        rd(16'h2000, 8'h5A, 0, 6'b000100, 16'h2000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
